// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use, memory-wait, multi-cycle-op and branch-flush handling.
// Stall/bubble/flush outputs are decoded combinationally from the FSM state and the current hazards.
module pipe_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       ifid_rs1,
  input  logic [4:0]       ifid_rs2,
  input  logic             idex_MemRead,
  input  logic [4:0]       idex_rd,
  input  logic             md_start,
  input  logic             md_done,
  input  logic             exmem_Branch,
  input  logic             exmem_PC_branch,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             idex_stall,
  output logic             exmem_stall,
  output logic             ifid_bubble,
  output logic             idex_bubble,
  output logic             exmem_bubble,
  output logic             memwb_bubble,
  output logic             pc_sel_branch,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {RUN = 2'd0, MEMWAIT = 2'd1, MDWAIT = 2'd2} state_t;

  // Control word: {pc_sel_branch, pc/ifid/idex/exmem stall, ifid/idex/exmem/memwb bubble}
  localparam logic [8:0] CTL_NONE  = 9'b0_0000_0000;
  localparam logic [8:0] CTL_TAKEN = 9'b1_0000_1110;
  localparam logic [8:0] CTL_MEM   = 9'b0_1111_0001;
  localparam logic [8:0] CTL_MD    = 9'b0_1110_0010;
  localparam logic [8:0] CTL_LU    = 9'b0_1100_0100;

  state_t     st, st_nxt;
  logic [8:0] ctl;
  logic       taken, loaduse, mem_wait;

  assign taken    = exmem_Branch & exmem_PC_branch;
  assign loaduse  = idex_MemRead & (idex_rd != 5'd0) &
                    ((idex_rd == ifid_rs1) | (idex_rd == ifid_rs2));
  assign mem_wait = mem_req & ~mem_ready;

  always_comb begin
    ctl    = CTL_NONE;
    st_nxt = st;
    case (st)
      RUN: begin
        if (taken)
          ctl = CTL_TAKEN;
        else if (mem_wait) begin
          ctl    = CTL_MEM;
          st_nxt = MEMWAIT;
        end else if (md_start) begin
          // A result that is ready in the issue cycle needs no stall.
          if (!md_done) begin
            ctl    = CTL_MD;
            st_nxt = MDWAIT;
          end
        end else if (loaduse)
          ctl = CTL_LU;
      end
      MEMWAIT: begin
        if (!mem_ready)
          ctl = CTL_MEM;
        else begin
          st_nxt = RUN;
          if (taken) ctl = CTL_TAKEN;
        end
      end
      MDWAIT: begin
        // EX/MEM holds a bubble while waiting, so any branch flag there is stale.
        if (!md_done) ctl = CTL_MD;
        else          st_nxt = RUN;
      end
      default: st_nxt = RUN;
    endcase
  end

  assign {pc_sel_branch, pc_stall, ifid_stall, idex_stall, exmem_stall,
          ifid_bubble, idex_bubble, exmem_bubble, memwb_bubble} = ctl;
  assign state = st;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st        <= RUN;
      stall_cnt <= '0;
    end else begin
      st <= st_nxt;
      if (pc_stall && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule
